// File: rtl/img_stream_tx.sv
// Streams an IMG_H x IMG_W image from a 1-cycle-latency memory NUM_DIM times,
// framed by volume, frame and line markers. No backpressure on the output stream.
module img_stream_tx #(
  parameter int unsigned IMA       = 8,
  parameter int unsigned IMG_W     = 32,
  parameter int unsigned IMG_H     = 32,
  parameter int unsigned NUM_DIM   = 5,
  parameter int unsigned FRAME_GAP = 4,
  parameter int unsigned AW        = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic           rd_en,
  output logic [AW-1:0]  rd_addr,
  input  logic [IMA-1:0] rd_data,
  output logic [IMA-1:0] ima,
  output logic           ena_out,
  output logic           frame_start_out,
  output logic           line_start_out,
  output logic           frame_end_out,
  output logic           frame_start_dim_out,
  output logic           frame_end_dim_out
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned DW   = (NUM_DIM > 1) ? $clog2(NUM_DIM) : 1;
  localparam int unsigned GW   = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);
  localparam logic [DW-1:0] DimLast = DW'(NUM_DIM - 1);
  localparam logic [GW-1:0] GapLast = GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

  typedef enum logic [2:0] {
    StIdle, StDimStart, StFrmStart, StStream, StGap, StDimEnd
  } state_e;

  state_e        state_q;
  logic [CW-1:0] col_q, col_nxt;
  logic [RW-1:0] row_q, row_nxt;
  logic [DW-1:0] dim_q;
  logic [GW-1:0] gap_q;
  logic          last_pix, next_last;

  // col_q/row_q always name the pixel currently on the output
  always_comb begin
    col_nxt = col_q + CW'(1);
    row_nxt = row_q;
    if (col_q == ColLast) begin
      col_nxt = '0;
      row_nxt = row_q + RW'(1);
    end
  end

  assign last_pix  = (col_q == ColLast) && (row_q == RowLast);
  assign next_last = (col_nxt == ColLast) && (row_nxt == RowLast);
  assign ima       = ena_out ? rd_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= StIdle;
      col_q               <= '0;
      row_q               <= '0;
      dim_q               <= '0;
      gap_q               <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      rd_en               <= 1'b0;
      rd_addr             <= '0;
      ena_out             <= 1'b0;
      frame_start_out     <= 1'b0;
      line_start_out      <= 1'b0;
      frame_end_out       <= 1'b0;
      frame_start_dim_out <= 1'b0;
      frame_end_dim_out   <= 1'b0;
    end else begin
      done                <= 1'b0;
      rd_en               <= 1'b0;
      ena_out             <= 1'b0;
      frame_start_out     <= 1'b0;
      line_start_out      <= 1'b0;
      frame_end_out       <= 1'b0;
      frame_start_dim_out <= 1'b0;
      frame_end_dim_out   <= 1'b0;
      if (abort && (state_q != StIdle)) begin
        state_q <= StIdle;
        busy    <= 1'b0;
        col_q   <= '0;
        row_q   <= '0;
        dim_q   <= '0;
        gap_q   <= '0;
        rd_addr <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start && !abort) begin
              state_q             <= StDimStart;
              busy                <= 1'b1;
              dim_q               <= '0;
              frame_start_dim_out <= 1'b1;
            end
          end
          StDimStart: begin
            state_q         <= StFrmStart;
            frame_start_out <= 1'b1;
            rd_en           <= 1'b1;
            rd_addr         <= '0;
            col_q           <= '0;
            row_q           <= '0;
          end
          StFrmStart: begin
            state_q        <= StStream;
            ena_out        <= 1'b1;
            line_start_out <= 1'b1;
            frame_end_out  <= (NPIX == 1);
            rd_en          <= (NPIX > 1);
            rd_addr        <= AW'(1);
          end
          StStream: begin
            if (last_pix) begin
              if (dim_q != DimLast) begin
                dim_q <= dim_q + DW'(1);
                if (FRAME_GAP == 0) begin
                  state_q         <= StFrmStart;
                  frame_start_out <= 1'b1;
                  rd_en           <= 1'b1;
                  rd_addr         <= '0;
                  col_q           <= '0;
                  row_q           <= '0;
                end else begin
                  state_q <= StGap;
                  gap_q   <= '0;
                end
              end else begin
                state_q           <= StDimEnd;
                frame_end_dim_out <= 1'b1;
                done              <= 1'b1;
              end
            end else begin
              col_q          <= col_nxt;
              row_q          <= row_nxt;
              ena_out        <= 1'b1;
              line_start_out <= (col_nxt == '0);
              frame_end_out  <= next_last;
              // Reads run one pixel ahead; stop once the last address has been issued
              rd_en          <= !next_last;
              if (!next_last) rd_addr <= rd_addr + AW'(1);
            end
          end
          StGap: begin
            if (gap_q == GapLast) begin
              state_q         <= StFrmStart;
              frame_start_out <= 1'b1;
              rd_en           <= 1'b1;
              rd_addr         <= '0;
              col_q           <= '0;
              row_q           <= '0;
              gap_q           <= '0;
            end else begin
              gap_q <= gap_q + GW'(1);
            end
          end
          StDimEnd: begin
            state_q <= StIdle;
            busy    <= 1'b0;
            dim_q   <= '0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_img_stream_tx.sv
// Scoreboard bench: a default 32x32x5 instance and a small 4x4x1 instance.
// Expected pixels/markers are queued at stimulus time; a negedge monitor pops and compares.
module tb_img_stream_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default instance
  logic       start0 = 1'b0, abort0 = 1'b0;
  logic       busy0, done0, rd_en0, ena0, fs0, ls0, fe0, fsd0, fed0;
  logic [9:0] rd_addr0;
  logic [7:0] rd_data0 = 8'h00, ima0;

  // Small instance
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic       busy1, done1, rd_en1, ena1, fs1, ls1, fe1, fsd1, fed1;
  logic [4:0] rd_addr1;
  logic [7:0] rd_data1 = 8'h00, ima1;

  img_stream_tx dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .busy(busy0), .done(done0),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0), .ima(ima0), .ena_out(ena0),
    .frame_start_out(fs0), .line_start_out(ls0), .frame_end_out(fe0),
    .frame_start_dim_out(fsd0), .frame_end_dim_out(fed0)
  );

  img_stream_tx #(
    .IMA(8), .IMG_W(4), .IMG_H(4), .NUM_DIM(1), .FRAME_GAP(0), .AW(5)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .busy(busy1), .done(done1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1), .ima(ima1), .ena_out(ena1),
    .frame_start_out(fs1), .line_start_out(ls1), .frame_end_out(fe1),
    .frame_start_dim_out(fsd1), .frame_end_dim_out(fed1)
  );

  // Memory models: data = low address bits, 0xEE when no read was issued
  always @(posedge clk) begin
    rd_data0 <= rd_en0 ? rd_addr0[7:0] : 8'hEE;
    rd_data1 <= rd_en1 ? {3'b000, rd_addr1} : 8'hEE;
  end

  typedef struct { int cyc; int pix; bit ls; bit fe; } pix_t;
  typedef struct { int cyc; int kind; } mark_t;  // kind: 0 fsd, 1 fs, 2 fed, 3 done

  pix_t  pix_q[2][$];
  mark_t mark_q[2][$];
  int    t0[2] = '{0, 0};
  int    n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_volume(input int d, input int base, input int w, input int h,
                             input int nd, input int gap, input int limit);
    int period, fs, c, fin;
    period = 1 + w * h + gap;
    if (base + 1 <= limit) mark_q[d].push_back('{base + 1, 0});
    for (int k = 0; k < nd; k++) begin
      fs = base + 2 + k * period;
      if (fs <= limit) mark_q[d].push_back('{fs, 1});
      for (int p = 0; p < w * h; p++) begin
        c = fs + 1 + p;
        if (c <= limit) pix_q[d].push_back('{c, p & 255, (p % w) == 0, p == w * h - 1});
      end
    end
    fin = base + 2 + (nd - 1) * period + w * h + 1;
    if (fin <= limit) begin
      mark_q[d].push_back('{fin, 2});
      mark_q[d].push_back('{fin, 3});
    end
  endtask

  task automatic check_cycle(input int d, input logic ena, input logic [7:0] ima,
                             input logic ls, input logic fe, input logic [3:0] marks);
    int   rel;
    pix_t e;
    mark_t m;
    rel = cyc - t0[d];
    if (ena) begin
      if (pix_q[d].size() == 0) begin
        chk($sformatf("dut%0d unexpected pixel at rel %0d", d, rel), 1, 0);
      end else begin
        e = pix_q[d].pop_front();
        chk($sformatf("dut%0d pixel cycle", d), rel, e.cyc);
        chk($sformatf("dut%0d ima @%0d", d, e.cyc), ima, e.pix);
        chk($sformatf("dut%0d line_start @%0d", d, e.cyc), ls, e.ls);
        chk($sformatf("dut%0d frame_end @%0d", d, e.cyc), fe, e.fe);
      end
    end else begin
      chk($sformatf("dut%0d idle ima/flags @%0d", d, rel), {ima, ls, fe}, 0);
    end
    for (int k = 0; k < 4; k++) begin
      if (marks[k]) begin
        if (mark_q[d].size() == 0) begin
          chk($sformatf("dut%0d unexpected marker %0d at rel %0d", d, k, rel), 1, 0);
        end else begin
          m = mark_q[d].pop_front();
          chk($sformatf("dut%0d marker kind @%0d", d, rel), k, m.kind);
          chk($sformatf("dut%0d marker %0d cycle", d, k), rel, m.cyc);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    check_cycle(0, ena0, ima0, ls0, fe0, {done0, fed0, fs0, fsd0});
    check_cycle(1, ena1, ima1, ls1, fe1, {done1, fed1, fs1, fsd1});
    if (rd_en1) chk("dut1 rd_addr in range", (rd_addr1 <= 5'd15), 1);
  end

  task automatic chk_quiet(input int d, input string tag, input bit with_addr);
    if (d == 0) begin
      chk({tag, " dut0 flags"}, {busy0, done0, rd_en0, ena0, fs0, ls0, fe0, fsd0, fed0}, 0);
      chk({tag, " dut0 ima"}, ima0, 0);
      if (with_addr) chk({tag, " dut0 rd_addr"}, rd_addr0, 0);
    end else begin
      chk({tag, " dut1 flags"}, {busy1, done1, rd_en1, ena1, fs1, ls1, fe1, fsd1, fed1}, 0);
      chk({tag, " dut1 ima"}, ima1, 0);
      if (with_addr) chk({tag, " dut1 rd_addr"}, rd_addr1, 0);
    end
  endtask

  task automatic wait_rel(input int d, input int c);
    while (cyc - t0[d] < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_drained(input int d, input string tag);
    chk({tag, " pixels left"}, pix_q[d].size(), 0);
    chk({tag, " markers left"}, mark_q[d].size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_quiet(0, "reset", 1'b1);
    chk_quiet(1, "reset", 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full default volume, with a second start while busy that must be ignored
    t0[0] = cyc;
    start0 = 1'b1;
    push_volume(0, 0, 32, 32, 5, 4, 1 << 30);
    @(posedge clk);
    #1;
    start0 = 1'b0;
    chk("busy after start", busy0, 1);
    wait_rel(0, 500);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    wait_rel(0, 5143);
    chk("busy during done", busy0, 1);
    chk("done pulse", done0, 1);
    wait_rel(0, 5144);
    chk("busy after volume", busy0, 0);
    chk("done one cycle", done0, 0);
    chk_drained(0, "full volume");

    // Abort mid-frame, then restart
    t0[0] = cyc;
    start0 = 1'b1;
    push_volume(0, 0, 32, 32, 5, 4, 1500);
    @(posedge clk);
    #1;
    start0 = 1'b0;
    wait_rel(0, 1500);
    abort0 = 1'b1;
    @(posedge clk);
    #1;
    abort0 = 1'b0;
    chk_quiet(0, "after abort", 1'b0);
    chk_drained(0, "abort");
    wait_rel(0, 1510);
    start0 = 1'b1;
    push_volume(0, 1510, 32, 32, 5, 4, 1 << 30);
    @(posedge clk);
    #1;
    start0 = 1'b0;
    chk("restart frame_start_dim", fsd0, 1);
    wait_rel(0, 1510 + 5144);
    chk("busy after restart volume", busy0, 0);
    chk_drained(0, "restart volume");

    // Small instance: one 4x4 frame, no gap
    t0[1] = cyc;
    start1 = 1'b1;
    push_volume(1, 0, 4, 4, 1, 0, 1 << 30);
    @(posedge clk);
    #1;
    start1 = 1'b0;
    wait_rel(1, 19);
    chk("small done", done1, 1);
    wait_rel(1, 20);
    chk("small busy low", busy1, 0);
    chk_drained(1, "small volume");

    // Small instance: async reset at cycle 10 clears outputs without end markers
    t0[1] = cyc;
    start1 = 1'b1;
    push_volume(1, 0, 4, 4, 1, 0, 9);
    @(posedge clk);
    #1;
    start1 = 1'b0;
    wait_rel(1, 10);
    #1;
    rst_n = 1'b0;
    #1;
    chk_quiet(1, "async reset", 1'b1);
    chk_quiet(0, "async reset", 1'b1);
    chk_drained(1, "async reset");
    #4;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_quiet(1, "after reset", 1'b1);
    chk_drained(1, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
